// File: rtl/mem_access_unit_if.sv
// Data-bus port bundle between the memory-access stage (master) and memory (slave).
interface mem_access_unit_if #(
  parameter int XLEN = 32
);
  logic              req_valid;
  logic              req_ready;
  logic [XLEN-1:0]   addr;
  logic              we;
  logic [XLEN/8-1:0] wstrb;
  logic [XLEN-1:0]   wdata;
  logic              rsp_valid;
  logic              rsp_err;
  logic [XLEN-1:0]   rdata;

  modport master (
    output req_valid, addr, we, wstrb, wdata,
    input  req_ready, rsp_valid, rsp_err, rdata
  );

  modport slave (
    input  req_valid, addr, we, wstrb, wdata,
    output req_ready, rsp_valid, rsp_err, rdata
  );
endinterface

// File: rtl/mem_access_unit.sv
// EX->WB memory-access stage: one op at a time, valid/ready data bus, load extension,
// misalignment/access-fault exceptions, forwarding and load-in-flight hazard info.
module mem_access_unit #(
  parameter int XLEN          = 32,
  parameter int RF_ADDR_WIDTH = 5,
  parameter int LANE_W        = $clog2(XLEN/8)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     ex_valid_i,
  output logic                     ex_ready_o,
  input  logic [XLEN-1:0]          ex_pc_i,
  input  logic [31:0]              ex_inst_i,
  input  logic                     ex_is_load_i,
  input  logic                     ex_is_store_i,
  input  logic                     ex_unsigned_i,
  input  logic [1:0]               ex_size_i,
  input  logic [XLEN-1:0]          ex_addr_i,
  input  logic [XLEN-1:0]          ex_sdata_i,
  input  logic [XLEN-1:0]          ex_alu_res_i,
  input  logic                     ex_req_rf_i,
  input  logic [RF_ADDR_WIDTH-1:0] ex_rf_waddr_i,
  input  logic                     ex_exp_i,
  input  logic [3:0]               ex_exp_cause_i,
  input  logic                     flush_i,
  mem_access_unit_if.master        bus,
  output logic                     wb_valid_o,
  output logic [XLEN-1:0]          wb_pc_o,
  output logic [31:0]              wb_inst_o,
  output logic                     wb_req_rf_o,
  output logic [RF_ADDR_WIDTH-1:0] wb_rf_waddr_o,
  output logic [XLEN-1:0]          wb_data_o,
  output logic                     wb_exp_o,
  output logic [3:0]               wb_exp_cause_o,
  output logic                     fw_valid_o,
  output logic [RF_ADDR_WIDTH-1:0] fw_rd_addr_o,
  output logic [XLEN-1:0]          fw_data_o,
  output logic                     ld_busy_o,
  output logic [RF_ADDR_WIDTH-1:0] ld_rd_o
);
  localparam int NB = XLEN/8;

  typedef enum logic [1:0] {IDLE, REQ, RESP, DRAIN} state_t;
  state_t state;

  logic [XLEN-1:0]          op_pc, op_alu;
  logic [31:0]              op_inst;
  logic                     op_load, op_uns, op_req_rf;
  logic [1:0]               op_size;
  logic [LANE_W-1:0]        op_lane;
  logic [RF_ADDR_WIDTH-1:0] op_rd;

  logic              req_valid_q, we_q;
  logic [XLEN-1:0]   addr_q, wdata_q;
  logic [NB-1:0]     wstrb_q;

  logic              is_mem, misal;
  logic [LANE_W-1:0] lane, lane_mask;
  logic [NB-1:0]     strb;
  logic [XLEN-1:0]   wdata_rep;

  // Shift the addressed lane down, then mask and sign/zero-fill above the field.
  function automatic logic [XLEN-1:0] extract(input logic [XLEN-1:0] rdata,
                                              input logic [LANE_W-1:0] ln,
                                              input logic [1:0] sz,
                                              input logic uns);
    logic [XLEN-1:0] s, mask;
    logic            sgn;
    s = rdata >> {ln, 3'b000};
    case (sz)
      2'd0:    mask = XLEN'(64'hFF);
      2'd1:    mask = XLEN'(64'hFFFF);
      2'd2:    mask = XLEN'(64'hFFFF_FFFF);
      default: mask = '1;
    endcase
    sgn = ~uns & (|(s & (mask ^ (mask >> 1))));
    return sgn ? (s | ~mask) : (s & mask);
  endfunction

  always_comb begin
    lane   = ex_addr_i[LANE_W-1:0];
    is_mem = ex_is_load_i | ex_is_store_i;
    case (ex_size_i)
      2'd0: begin lane_mask = '0;              strb = NB'(8'h01); wdata_rep = {NB{ex_sdata_i[7:0]}}; end
      2'd1: begin lane_mask = LANE_W'(3'd1);   strb = NB'(8'h03); wdata_rep = {(NB/2){ex_sdata_i[15:0]}}; end
      2'd2: begin lane_mask = LANE_W'(3'd3);   strb = NB'(8'h0F); wdata_rep = {(NB/4){ex_sdata_i[31:0]}}; end
      default: begin lane_mask = LANE_W'(3'd7); strb = NB'(8'hFF); wdata_rep = ex_sdata_i; end
    endcase
    strb  = strb << lane;
    misal = (|(lane & lane_mask)) || (XLEN == 32 && ex_size_i == 2'd3);
  end

  assign ex_ready_o    = (state == IDLE);
  assign bus.req_valid = req_valid_q;
  assign bus.addr      = addr_q;
  assign bus.we        = we_q;
  assign bus.wstrb     = wstrb_q;
  assign bus.wdata     = wdata_q;
  assign fw_valid_o    = wb_valid_o & wb_req_rf_o;
  assign fw_rd_addr_o  = wb_rf_waddr_o;
  assign fw_data_o     = wb_data_o;
  assign ld_busy_o     = op_load && (state == REQ || state == RESP);
  assign ld_rd_o       = ld_busy_o ? op_rd : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      op_pc <= '0; op_alu <= '0; op_inst <= '0; op_load <= 1'b0; op_uns <= 1'b0;
      op_req_rf <= 1'b0; op_size <= '0; op_lane <= '0; op_rd <= '0;
      req_valid_q <= 1'b0; we_q <= 1'b0; addr_q <= '0; wdata_q <= '0; wstrb_q <= '0;
      wb_valid_o <= 1'b0; wb_pc_o <= '0; wb_inst_o <= '0; wb_req_rf_o <= 1'b0;
      wb_rf_waddr_o <= '0; wb_data_o <= '0; wb_exp_o <= 1'b0; wb_exp_cause_o <= '0;
    end else begin
      wb_valid_o <= 1'b0;
      case (state)
        IDLE: if (ex_valid_i && !flush_i) begin
          if (!is_mem || ex_exp_i || misal) begin
            wb_valid_o     <= 1'b1;
            wb_pc_o        <= ex_pc_i;
            wb_inst_o      <= ex_inst_i;
            wb_rf_waddr_o  <= ex_rf_waddr_i;
            wb_data_o      <= ex_alu_res_i;
            wb_exp_o       <= ex_exp_i | (is_mem & misal);
            wb_exp_cause_o <= ex_exp_i ? ex_exp_cause_i :
                              (is_mem & misal) ? (ex_is_load_i ? 4'd4 : 4'd6) : 4'd0;
            wb_req_rf_o    <= ex_req_rf_i & ~ex_exp_i & ~(is_mem & misal) & ~ex_is_store_i;
          end else begin
            op_pc       <= ex_pc_i;
            op_inst     <= ex_inst_i;
            op_alu      <= ex_alu_res_i;
            op_load     <= ex_is_load_i;
            op_uns      <= ex_unsigned_i;
            op_req_rf   <= ex_req_rf_i & ~ex_is_store_i & ex_is_load_i;
            op_size     <= ex_size_i;
            op_lane     <= lane;
            op_rd       <= ex_rf_waddr_i;
            req_valid_q <= 1'b1;
            addr_q      <= {ex_addr_i[XLEN-1:LANE_W], {LANE_W{1'b0}}};
            we_q        <= ~ex_is_load_i;
            wstrb_q     <= ex_is_load_i ? '0 : strb;
            wdata_q     <= ex_is_load_i ? '0 : wdata_rep;
            state       <= REQ;
          end
        end
        // A flush that coincides with the handshake must still absorb the response.
        REQ: if (bus.req_ready) begin
          req_valid_q <= 1'b0;
          state       <= flush_i ? DRAIN : RESP;
        end else if (flush_i) begin
          req_valid_q <= 1'b0;
          state       <= IDLE;
        end
        RESP: if (flush_i) begin
          state <= bus.rsp_valid ? IDLE : DRAIN;
        end else if (bus.rsp_valid) begin
          wb_valid_o     <= 1'b1;
          wb_pc_o        <= op_pc;
          wb_inst_o      <= op_inst;
          wb_rf_waddr_o  <= op_rd;
          wb_data_o      <= op_load ? extract(bus.rdata, op_lane, op_size, op_uns) : op_alu;
          wb_exp_o       <= bus.rsp_err;
          wb_exp_cause_o <= bus.rsp_err ? (op_load ? 4'd5 : 4'd7) : 4'd0;
          wb_req_rf_o    <= op_req_rf & ~bus.rsp_err;
          state          <= IDLE;
        end
        DRAIN: if (bus.rsp_valid) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_access_unit.sv
// Table-driven bench with a WB scoreboard for XLEN=32, plus hand sequences for
// flush/reset corners and an XLEN=64 instance for wide-lane stores and loads.
module tb_mem_access_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_run = 0;
  int n_fail = 0;

  // ---------------- XLEN=32 instance ----------------
  logic        ex_valid = 0, ex_ready, flush = 0;
  logic [31:0] ex_pc = 0, ex_inst = 0, addr = 0, sdata = 0, alu = 0;
  logic        is_ld = 0, is_st = 0, uns = 0, req_rf = 0, exp_in = 0;
  logic [1:0]  size = 0;
  logic [4:0]  rd = 0;
  logic [3:0]  cause_in = 0;
  logic        wb_valid, wb_req_rf, wb_exp, fw_valid, ld_busy;
  logic [31:0] wb_pc, wb_inst, wb_data, fw_data;
  logic [4:0]  wb_rd, fw_rd, ld_rd;
  logic [3:0]  wb_cause;

  mem_access_unit_if #(.XLEN(32)) bus32 ();

  mem_access_unit #(.XLEN(32), .RF_ADDR_WIDTH(5)) u32 (
    .clk(clk), .rst_n(rst_n), .ex_valid_i(ex_valid), .ex_ready_o(ex_ready),
    .ex_pc_i(ex_pc), .ex_inst_i(ex_inst), .ex_is_load_i(is_ld), .ex_is_store_i(is_st),
    .ex_unsigned_i(uns), .ex_size_i(size), .ex_addr_i(addr), .ex_sdata_i(sdata),
    .ex_alu_res_i(alu), .ex_req_rf_i(req_rf), .ex_rf_waddr_i(rd), .ex_exp_i(exp_in),
    .ex_exp_cause_i(cause_in), .flush_i(flush), .bus(bus32.master),
    .wb_valid_o(wb_valid), .wb_pc_o(wb_pc), .wb_inst_o(wb_inst), .wb_req_rf_o(wb_req_rf),
    .wb_rf_waddr_o(wb_rd), .wb_data_o(wb_data), .wb_exp_o(wb_exp), .wb_exp_cause_o(wb_cause),
    .fw_valid_o(fw_valid), .fw_rd_addr_o(fw_rd), .fw_data_o(fw_data),
    .ld_busy_o(ld_busy), .ld_rd_o(ld_rd)
  );

  // ---------------- XLEN=64 instance ----------------
  logic        ex_valid6 = 0, ex_ready6;
  logic [63:0] ex_pc6 = 0, addr6 = 0, sdata6 = 0, alu6 = 0;
  logic [31:0] ex_inst6 = 0;
  logic        is_ld6 = 0, is_st6 = 0, uns6 = 0;
  logic [1:0]  size6 = 0;
  logic        wb_valid6, wb_req_rf6, wb_exp6, fw_valid6, ld_busy6;
  logic [63:0] wb_pc6, wb_data6, fw_data6;
  logic [31:0] wb_inst6;
  logic [4:0]  wb_rd6, fw_rd6, ld_rd6;
  logic [3:0]  wb_cause6;

  mem_access_unit_if #(.XLEN(64)) bus64 ();

  mem_access_unit #(.XLEN(64), .RF_ADDR_WIDTH(5)) u64 (
    .clk(clk), .rst_n(rst_n), .ex_valid_i(ex_valid6), .ex_ready_o(ex_ready6),
    .ex_pc_i(ex_pc6), .ex_inst_i(ex_inst6), .ex_is_load_i(is_ld6), .ex_is_store_i(is_st6),
    .ex_unsigned_i(uns6), .ex_size_i(size6), .ex_addr_i(addr6), .ex_sdata_i(sdata6),
    .ex_alu_res_i(alu6), .ex_req_rf_i(1'b1), .ex_rf_waddr_i(5'd9), .ex_exp_i(1'b0),
    .ex_exp_cause_i(4'd0), .flush_i(1'b0), .bus(bus64.master),
    .wb_valid_o(wb_valid6), .wb_pc_o(wb_pc6), .wb_inst_o(wb_inst6), .wb_req_rf_o(wb_req_rf6),
    .wb_rf_waddr_o(wb_rd6), .wb_data_o(wb_data6), .wb_exp_o(wb_exp6), .wb_exp_cause_o(wb_cause6),
    .fw_valid_o(fw_valid6), .fw_rd_addr_o(fw_rd6), .fw_data_o(fw_data6),
    .ld_busy_o(ld_busy6), .ld_rd_o(ld_rd6)
  );

  initial begin
    bus32.req_ready = 0; bus32.rsp_valid = 0; bus32.rsp_err = 0; bus32.rdata = '0;
    bus64.req_ready = 0; bus64.rsp_valid = 0; bus64.rsp_err = 0; bus64.rdata = '0;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_run++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [31:0] pc, data;
    logic [4:0]  rd;
    logic        exp, rf;
    logic [3:0]  cause;
  } wb_rec_t;
  wb_rec_t q[$];

  always @(negedge clk) begin
    wb_rec_t e;
    if (rst_n && wb_valid) begin
      if (q.size() == 0) begin
        n_run++; n_fail++;
        $display("FAIL wb_unexpected: got pulse pc=%h, expected none", wb_pc);
      end else begin
        e = q.pop_front();
        chk("wb_pc", wb_pc, e.pc);
        chk("wb_data", wb_data, e.data);
        chk("wb_exp", wb_exp, e.exp);
        chk("wb_cause", wb_cause, e.cause);
        chk("wb_req_rf", wb_req_rf, e.rf);
        chk("fw_valid", fw_valid, e.rf);
        chk("fw_rd", fw_rd, e.rd);
        chk("fw_data", fw_data, e.data);
      end
    end
  end

  // ---------------- vector table ----------------
  typedef struct {
    logic ld, st, uns; logic [1:0] size;
    logic [31:0] addr, sdata, alu, rdata;
    logic rf, exp; logic [3:0] cause; logic err; int rwait, swait;
    logic bus; logic [3:0] e_strb; logic [31:0] e_wdata, e_data;
    logic e_exp; logic [3:0] e_cause; logic e_rf;
  } vec_t;

  function automatic vec_t mkv(logic ld, logic st, logic u, logic [1:0] sz, logic [31:0] a,
                               logic [31:0] sd, logic [31:0] al, logic [31:0] rdat, logic rf,
                               logic ex, logic [3:0] c, logic er, int rw, int sw, logic b,
                               logic [3:0] es, logic [31:0] ew, logic [31:0] ed, logic ee,
                               logic [3:0] ec, logic erf);
    vec_t v;
    v.ld = ld; v.st = st; v.uns = u; v.size = sz; v.addr = a; v.sdata = sd; v.alu = al;
    v.rdata = rdat; v.rf = rf; v.exp = ex; v.cause = c; v.err = er; v.rwait = rw; v.swait = sw;
    v.bus = b; v.e_strb = es; v.e_wdata = ew; v.e_data = ed; v.e_exp = ee; v.e_cause = ec;
    v.e_rf = erf;
    return v;
  endfunction

  task automatic wait_ready();
    int n = 0;
    while (!ex_ready && n < 20) begin step(); n++; end
    if (!ex_ready) chk("ex_ready_timeout", ex_ready, 1);
  endtask

  task automatic run_vec(input int i, input vec_t v);
    wb_rec_t e;
    wait_ready();
    ex_pc = 32'h100 + 32'(i * 4); ex_inst = 32'(i); rd = 5'(i + 5);
    is_ld = v.ld; is_st = v.st; uns = v.uns; size = v.size; addr = v.addr;
    sdata = v.sdata; alu = v.alu; req_rf = v.rf; exp_in = v.exp; cause_in = v.cause;
    ex_valid = 1;
    e.pc = ex_pc; e.data = v.e_data; e.rd = rd; e.exp = v.e_exp; e.rf = v.e_rf; e.cause = v.e_cause;
    q.push_back(e);
    step();
    ex_valid = 0;
    if (!v.bus) begin
      chk("lat1_wb_valid", wb_valid, 1);
      chk("no_bus_req", bus32.req_valid, 0);
    end else begin
      chk("req_valid", bus32.req_valid, 1);
      chk("bus_addr", bus32.addr, {v.addr[31:2], 2'b00});
      chk("bus_we", bus32.we, v.st);
      chk("bus_wstrb", bus32.wstrb, v.e_strb);
      if (v.st) chk("bus_wdata", bus32.wdata, v.e_wdata);
      for (int k = 0; k < v.rwait; k++) begin
        chk("req_hold", bus32.req_valid, 1);
        chk("ex_ready_busy", ex_ready, 0);
        chk("ld_busy", ld_busy, v.ld);
        if (v.ld) chk("ld_rd", ld_rd, rd);
        step();
      end
      bus32.req_ready = 1; step(); bus32.req_ready = 0;
      for (int k = 0; k < v.swait; k++) begin
        chk("req_dropped", bus32.req_valid, 0);
        chk("ex_ready_resp", ex_ready, 0);
        chk("ld_busy_resp", ld_busy, v.ld);
        chk("no_early_wb", wb_valid, 0);
        step();
      end
      bus32.rsp_valid = 1; bus32.rdata = v.rdata; bus32.rsp_err = v.err;
      step();
      bus32.rsp_valid = 0; bus32.rsp_err = 0;
      chk("lat_wb_valid", wb_valid, 1);
      chk("ready_at_wb", ex_ready, 1);
    end
  endtask

  task automatic run64(input logic ld, input logic u, input logic [1:0] sz, input logic [63:0] a,
                       input logic [63:0] sd, input logic [63:0] rdat, input logic [7:0] es,
                       input logic [63:0] ew, input logic [63:0] ed, input logic erf);
    is_ld6 = ld; is_st6 = ~ld; uns6 = u; size6 = sz; addr6 = a; sdata6 = sd; alu6 = a;
    ex_valid6 = 1; step(); ex_valid6 = 0;
    chk("b64_req_valid", bus64.req_valid, 1);
    chk("b64_addr", bus64.addr, {a[63:3], 3'b000});
    chk("b64_wstrb", bus64.wstrb, es);
    if (!ld) chk("b64_wdata", bus64.wdata, ew);
    bus64.req_ready = 1; step(); bus64.req_ready = 0;
    bus64.rsp_valid = 1; bus64.rdata = rdat; step(); bus64.rsp_valid = 0;
    chk("b64_wb_valid", wb_valid6, 1);
    chk("b64_wb_data", wb_data6, ed);
    chk("b64_wb_req_rf", wb_req_rf6, erf);
    chk("b64_wb_exp", wb_exp6, 0);
  endtask

  vec_t tbl[17];

  initial begin
    //             ld st u sz addr          sdata         alu           rdata         rf ex c  er rw sw bus strb  wdata         data          ee ec erf
    tbl[0]  = mkv(0, 0, 0, 2, 32'h0,        32'h0,        32'h1234,     32'h0,        1, 0, 0, 0, 0, 0, 0, 4'h0, 32'h0,        32'h1234,     0, 0, 1);
    tbl[1]  = mkv(1, 0, 0, 0, 32'h1003,     32'h0,        32'h1003,     32'h80FF0000, 1, 0, 0, 0, 0, 0, 1, 4'h0, 32'h0,        32'hFFFFFF80, 0, 0, 1);
    tbl[2]  = mkv(1, 0, 1, 0, 32'h1003,     32'h0,        32'h1003,     32'h80FF0000, 1, 0, 0, 0, 0, 0, 1, 4'h0, 32'h0,        32'h00000080, 0, 0, 1);
    tbl[3]  = mkv(1, 0, 1, 1, 32'h1002,     32'h0,        32'h1002,     32'h80FF0000, 1, 0, 0, 0, 0, 0, 1, 4'h0, 32'h0,        32'h000080FF, 0, 0, 1);
    tbl[4]  = mkv(1, 0, 0, 1, 32'h1002,     32'h0,        32'h1002,     32'h80FF0000, 1, 0, 0, 0, 1, 0, 1, 4'h0, 32'h0,        32'hFFFF80FF, 0, 0, 1);
    tbl[5]  = mkv(1, 0, 0, 2, 32'h1000,     32'h0,        32'h1000,     32'hDEADBEEF, 1, 0, 0, 0, 3, 2, 1, 4'h0, 32'h0,        32'hDEADBEEF, 0, 0, 1);
    tbl[6]  = mkv(0, 1, 0, 2, 32'h2000,     32'hCAFEF00D, 32'h2000,     32'h0,        1, 0, 0, 0, 0, 1, 1, 4'hF, 32'hCAFEF00D, 32'h2000,     0, 0, 0);
    tbl[7]  = mkv(0, 1, 0, 0, 32'h2001,     32'h123456AB, 32'h2001,     32'h0,        0, 0, 0, 0, 2, 0, 1, 4'h2, 32'hABABABAB, 32'h2001,     0, 0, 0);
    tbl[8]  = mkv(0, 1, 0, 1, 32'h2002,     32'h0000BEEF, 32'h2002,     32'h0,        0, 0, 0, 0, 0, 0, 1, 4'hC, 32'hBEEFBEEF, 32'h2002,     0, 0, 0);
    tbl[9]  = mkv(1, 0, 0, 2, 32'h1002,     32'h0,        32'h1002,     32'h0,        1, 0, 0, 0, 0, 0, 0, 4'h0, 32'h0,        32'h1002,     1, 4, 0);
    tbl[10] = mkv(0, 1, 0, 1, 32'h2001,     32'h0,        32'h2001,     32'h0,        0, 0, 0, 0, 0, 0, 0, 4'h0, 32'h0,        32'h2001,     1, 6, 0);
    tbl[11] = mkv(1, 0, 0, 3, 32'h1000,     32'h0,        32'h1000,     32'h0,        1, 0, 0, 0, 0, 0, 0, 4'h0, 32'h0,        32'h1000,     1, 4, 0);
    tbl[12] = mkv(0, 1, 0, 2, 32'h2004,     32'h55AA55AA, 32'h2004,     32'h0,        0, 0, 0, 1, 0, 0, 1, 4'hF, 32'h55AA55AA, 32'h2004,     1, 7, 0);
    tbl[13] = mkv(1, 0, 0, 2, 32'h1004,     32'h0,        32'h1004,     32'h11223344, 1, 0, 0, 1, 0, 1, 1, 4'h0, 32'h0,        32'h11223344, 1, 5, 0);
    tbl[14] = mkv(0, 0, 0, 2, 32'h0,        32'h0,        32'h55,       32'h0,        1, 1, 2, 0, 0, 0, 0, 4'h0, 32'h0,        32'h55,       1, 2, 0);
    tbl[15] = mkv(1, 0, 0, 2, 32'h1000,     32'h0,        32'h1000,     32'h0,        1, 1, 3, 0, 0, 0, 0, 4'h0, 32'h0,        32'h1000,     1, 3, 0);
    tbl[16] = mkv(1, 0, 0, 0, 32'h1001,     32'h0,        32'h1001,     32'h00007F00, 1, 0, 0, 0, 1, 0, 1, 4'h0, 32'h0,        32'h0000007F, 0, 0, 1);

    // Reset state, sampled while reset is held.
    #12;
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_fw_valid", fw_valid, 0);
    chk("rst_req_valid", bus32.req_valid, 0);
    chk("rst_ld_busy", ld_busy, 0);
    chk("rst_ex_ready", ex_ready, 1);
    chk("rst_wb_data", wb_data, 0);
    step(); rst_n = 1; step();
    chk("post_rst_ex_ready", ex_ready, 1);

    foreach (tbl[i]) run_vec(i, tbl[i]);
    step(); step();
    chk("scoreboard_drained", 32'(q.size()), 0);

    // Flush on the accepting cycle drops the op.
    wait_ready();
    is_ld = 0; is_st = 0; alu = 32'h77; req_rf = 1; exp_in = 0; ex_valid = 1; flush = 1;
    step(); ex_valid = 0; flush = 0;
    chk("flush_accept_no_wb", wb_valid, 0);
    chk("flush_accept_ready", ex_ready, 1);

    // Flush in REQ withdraws the request.
    is_ld = 1; size = 2; addr = 32'h3000; rd = 5'd7; ex_valid = 1;
    step(); ex_valid = 0;
    chk("flreq_req_valid", bus32.req_valid, 1);
    chk("flreq_ld_rd", ld_rd, 7);
    flush = 1; step(); flush = 0;
    chk("flreq_req_dropped", bus32.req_valid, 0);
    chk("flreq_ld_busy", ld_busy, 0);
    chk("flreq_ready", ex_ready, 1);
    step();
    chk("flreq_no_wb", wb_valid, 0);

    // Flush in RESP: DRAIN swallows the late response.
    ex_valid = 1; step(); ex_valid = 0;
    bus32.req_ready = 1; step(); bus32.req_ready = 0;
    chk("flrsp_ld_busy", ld_busy, 1);
    flush = 1; step(); flush = 0;
    chk("flrsp_drain_not_ready", ex_ready, 0);
    chk("flrsp_drain_ld_busy", ld_busy, 0);
    step();
    chk("flrsp_still_drain", ex_ready, 0);
    bus32.rsp_valid = 1; bus32.rdata = 32'hBAD0BAD0; step(); bus32.rsp_valid = 0;
    chk("flrsp_no_wb", wb_valid, 0);
    chk("flrsp_idle", ex_ready, 1);

    // Reset mid-transaction returns to IDLE immediately.
    ex_valid = 1; step(); ex_valid = 0;
    chk("rstmid_req_valid", bus32.req_valid, 1);
    rst_n = 0; #1;
    chk("rstmid_req_cleared", bus32.req_valid, 0);
    chk("rstmid_ready", ex_ready, 1);
    chk("rstmid_ld_busy", ld_busy, 0);
    step(); rst_n = 1; step();
    chk("rstmid_no_wb", wb_valid, 0);

    // XLEN=64: SH at lane 6, signed LW at lane 4, LD.
    run64(0, 0, 1, 64'h1006, 64'hBEEF, 64'h0, 8'hC0, 64'hBEEFBEEFBEEFBEEF, 64'h1006, 0);
    run64(1, 0, 2, 64'h1004, 64'h0, 64'h80000000_00000000, 8'h00, 64'h0, 64'hFFFFFFFF_80000000, 1);
    run64(1, 0, 3, 64'h1008, 64'h0, 64'h8123456789ABCDEF, 8'h00, 64'h0, 64'h8123456789ABCDEF, 1);

    step(); step();
    chk("scoreboard_final", 32'(q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1);
  end
endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Parametrised, sequential memory-access pipeline stage sitting between EX and WB. It accepts one instruction at a time from EX and issues loads and stores on a valid/ready data bus, waiting any number of cycles for the response. It sign- or zero-extends load data for XLEN 32 or 64, raises misalignment and access-fault exceptions, and registers the result toward WB. It also provides forwarding and load-in-flight hazard information.

## Interface
- XLEN, 32: datapath width; 32 or 64.
- RF_ADDR_WIDTH, 5: register-file address width.
- LANE_W, log2(XLEN/8): number of byte-lane address bits (derived).
- clk  in  1  clock.
- rst_n  in  1  reset; asynchronous, active-low.
- ex_valid_i / ex_ready_o  in/out  1  EX→MEM handshake.
- ex_pc_i, ex_inst_i  in  XLEN/32  PC and instruction, passed through.
- ex_is_load_i, ex_is_store_i, ex_unsigned_i  in  1  op class; load extension mode.
- ex_size_i  in  2  0 byte, 1 half, 2 word, 3 dword.
- ex_addr_i, ex_sdata_i, ex_alu_res_i  in  XLEN  effective address, store data, ALU result.
- ex_req_rf_i, ex_rf_waddr_i  in  1/RF_ADDR_WIDTH  RF write request and destination.
- ex_exp_i, ex_exp_cause_i  in  1/4  upstream exception and its cause.
- flush_i  in  1  kill the in-flight op (interrupt or trap redirect).
- bus_req_valid_o / bus_req_ready_i  out/in  1  request handshake.
- bus_addr_o  out  XLEN  word-aligned address; lane bits are 0.
- bus_we_o, bus_wstrb_o, bus_wdata_o  out  1/XLEN/8/XLEN  write enable, byte strobes, lane-replicated store data.
- bus_rsp_valid_i, bus_rsp_err_i, bus_rdata_i  in  1/1/XLEN  response.
- wb_valid_o  out  1  one-cycle result pulse; WB never back-pressures.
- wb_pc_o, wb_inst_o, wb_req_rf_o, wb_rf_waddr_o, wb_data_o  out  -  registered result.
- wb_exp_o, wb_exp_cause_o  out  1/4  registered exception.
- fw_valid_o, fw_rd_addr_o, fw_data_o  out  -  forwarding from the WB-output register (fw_valid_o = wb_valid_o & wb_req_rf_o).
- ld_busy_o, ld_rd_o  out  1/RF_ADDR_WIDTH  a load is in flight; its destination, for the hazard unit.

## Operation
- States: IDLE, REQ, RESP, DRAIN. ex_ready_o = (state==IDLE).
- IDLE accept with flush_i=1: op dropped, no wb_valid_o.
- IDLE accept of a non-memory op, or any op with ex_exp_i or a misaligned address: the result is registered and wb_valid_o=1 next cycle; no bus access; stays IDLE.
- Misaligned: address not a multiple of the access size, or size 3 when XLEN=32. Cause 4 for loads, 6 for stores. ex_exp_i takes priority and passes ex_exp_cause_i through.
- IDLE accept of an aligned load or store: operands are latched and the state goes to REQ.
- REQ: bus_req_valid_o=1 with stable address, strobes and data until bus_req_ready_i. On handshake the state goes to RESP.
- flush_i in REQ before the handshake: drop the request and go to IDLE.
- RESP: on bus_rsp_valid_i, register the result, pulse wb_valid_o, and go to IDLE.
- bus_rsp_err_i: exception with cause 5 for loads, 7 for stores.
- flush_i in RESP: go to DRAIN. DRAIN waits for bus_rsp_valid_i, discards it, and goes to IDLE with no wb_valid_o.
- Load extract: lane = addr[LANE_W-1:0]. The field is rdata[lane*8 +: size bytes], sign-extended unless ex_unsigned_i.
- Store: wstrb = ((1<<bytes)-1) << lane; wdata = sdata[size bytes] replicated across XLEN.
- wb_data_o: the extracted load data for loads; otherwise ex_alu_res_i.
- wb_req_rf_o = req_rf & ~exception. Stores force wb_req_rf_o=0.
- ld_busy_o = 1 while in REQ or RESP holding a load; ld_rd_o is its destination.

## Timing
- Reset: state IDLE. Every output register is 0, so wb_*, fw_*, bus_req_valid_o and ld_busy_o are 0. ex_ready_o=1 during and after reset.
- Non-memory op: accepted at cycle T, wb_valid_o at T+1.
- Memory op, bus zero-wait: accepted at T, request at T+1 (ready), response at T+2, wb_valid_o at T+3.
- Each extra ready or response wait cycle adds one cycle. A response in the same cycle as the handshake is not allowed; the bus guarantees it arrives at least one cycle later.
- The next instruction is accepted in the same cycle wb_valid_o is asserted.
- Reset asserted mid-transaction: immediate return to IDLE with outputs cleared; the outstanding bus response is the bus's responsibility.

## Test plan
- XLEN=32, ALU op alu_res=0x1234, rd=5: wb_valid_o at T+1, wb_data_o=0x1234, fw_rd_addr_o=5.
- XLEN=32, LB at addr 0x...3, rdata=0x80FF_0000: wb_data_o=0xFFFF_FF80. LBU gives 0x0000_0080. LHU at addr 0x...2 gives 0x0000_80FF.
- XLEN=64, SH at addr 0x...6, sdata=0xBEEF: bus_wstrb_o=0xC0, bus_wdata_o=0xBEEF replicated 4×. wb_req_rf_o=0.
- LW at addr 0x...2: no bus request, wb_exp_o=1 with cause 4 at T+1. bus_rsp_err_i on a store gives cause 7.
- bus_req_ready_i held low 3 cycles, then the response 2 cycles later: ex_ready_o=0 and ld_busy_o=1 throughout, wb_valid_o exactly once.
- flush_i in REQ: request withdrawn, no wb_valid_o. flush_i in RESP: DRAIN, the late response is discarded, IDLE afterwards.
